// File: rtl/datapath_pkg.sv
// Shared constants for the two-stage datapath: ALU opcodes and default sizing.
package datapath_pkg;

  localparam int unsigned DefaultWidth = 32;
  localparam int unsigned DefaultNregs = 8;

  localparam logic [2:0] OpAnd  = 3'b000;
  localparam logic [2:0] OpOr   = 3'b001;
  localparam logic [2:0] OpAdd  = 3'b010;
  localparam logic [2:0] OpXor  = 3'b011;
  localparam logic [2:0] OpNor  = 3'b100;
  localparam logic [2:0] OpNone = 3'b101;
  localparam logic [2:0] OpSub  = 3'b110;
  localparam logic [2:0] OpSlt  = 3'b111;

endpackage

// File: rtl/pipelined_datapath_if.sv
// Operation issue and result bundle for pipelined_datapath.
interface pipelined_datapath_if
  import datapath_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth,
  parameter int unsigned AW    = $clog2(DefaultNregs)
);
  logic             valid_in;
  logic             hold;
  logic             wr;
  logic [2:0]       ALUControl;
  logic [AW-1:0]    addr1;
  logic [AW-1:0]    addr2;
  logic [AW-1:0]    addr3;
  logic             use_imm;
  logic [WIDTH-1:0] imm;
  logic             clr_ovf;
  logic [WIDTH-1:0] Result;
  logic             Zero;
  logic             Overflow;
  logic             valid_out;
  logic             ovf_sticky;

  modport master (
    output valid_in, hold, wr, ALUControl, addr1, addr2, addr3, use_imm, imm, clr_ovf,
    input  Result, Zero, Overflow, valid_out, ovf_sticky
  );

  modport slave (
    input  valid_in, hold, wr, ALUControl, addr1, addr2, addr3, use_imm, imm, clr_ovf,
    output Result, Zero, Overflow, valid_out, ovf_sticky
  );
endinterface

// File: rtl/alu_param.sv
// Combinational ALU with two's-complement wrap and signed-overflow detection.
module alu_param
  import datapath_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] result,
  output logic             overflow
);
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic             add_ovf;
  logic             sub_ovf;
  logic             lt;

  assign sum     = a + b;
  assign diff    = a - b;
  assign add_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
  assign sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
  // Difference sign flipped on overflow gives the true signed comparison.
  assign lt      = diff[WIDTH-1] ^ sub_ovf;

  always_comb begin
    result   = '0;
    overflow = 1'b0;
    case (op)
      OpAnd: result = a & b;
      OpOr:  result = a | b;
      OpXor: result = a ^ b;
      OpNor: result = ~(a | b);
      OpAdd: begin
        result   = sum;
        overflow = add_ovf;
      end
      OpSub: begin
        result   = diff;
        overflow = sub_ovf;
      end
      OpSlt: result = {{(WIDTH-1){1'b0}}, lt};
      default: result = '0;
    endcase
  end
endmodule

// File: rtl/pipelined_datapath.sv
// Two-stage issue/execute datapath with inline register file and full bypass
// from the execute stage, so dependent operations never stall.
module pipelined_datapath
  import datapath_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth,
  parameter int unsigned NREGS = DefaultNregs,
  localparam int unsigned AW   = $clog2(NREGS)
) (
  input logic                clk,
  input logic                rst,
  pipelined_datapath_if.slave bus
);
  logic [WIDTH-1:0] regs_q [NREGS];

  logic             s_valid_q;
  logic             s_wr_q;
  logic [AW-1:0]    s_addr3_q;
  logic [2:0]       s_op_q;
  logic [WIDTH-1:0] s_a_q;
  logic [WIDTH-1:0] s_b_q;

  logic [WIDTH-1:0] res_q;
  logic             zero_q;
  logic             ovf_q;
  logic             valid_q;
  logic             sticky_q;

  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf;
  logic             fwd;
  logic [WIDTH-1:0] opnd_a;
  logic [WIDTH-1:0] rd_b;
  logic [WIDTH-1:0] opnd_b;

  alu_param #(
    .WIDTH(WIDTH)
  ) u_alu (
    .a       (s_a_q),
    .b       (s_b_q),
    .op      (s_op_q),
    .result  (alu_res),
    .overflow(alu_ovf)
  );

  // The op in the stage register writes back on the next edge; forward it now.
  assign fwd    = s_valid_q && s_wr_q;
  assign opnd_a = (fwd && (s_addr3_q == bus.addr1)) ? alu_res : regs_q[bus.addr1];
  assign rd_b   = (fwd && (s_addr3_q == bus.addr2)) ? alu_res : regs_q[bus.addr2];
  assign opnd_b = bus.use_imm ? bus.imm : rd_b;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_valid_q <= 1'b0;
      s_wr_q    <= 1'b0;
      s_addr3_q <= '0;
      s_op_q    <= '0;
      s_a_q     <= '0;
      s_b_q     <= '0;
    end else if (!bus.hold) begin
      s_valid_q <= bus.valid_in;
      s_wr_q    <= bus.wr;
      s_addr3_q <= bus.addr3;
      s_op_q    <= bus.ALUControl;
      s_a_q     <= opnd_a;
      s_b_q     <= opnd_b;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (!bus.hold && fwd) begin
      regs_q[s_addr3_q] <= alu_res;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (!bus.hold) begin
      valid_q <= s_valid_q;
      if (s_valid_q) begin
        res_q  <= alu_res;
        zero_q <= (alu_res == '0);
        ovf_q  <= alu_ovf;
      end
    end
  end

  // A new overflow beats a simultaneous clear; clear still works under hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sticky_q <= 1'b0;
    end else if (!bus.hold && s_valid_q && alu_ovf) begin
      sticky_q <= 1'b1;
    end else if (bus.clr_ovf) begin
      sticky_q <= 1'b0;
    end
  end

  assign bus.Result     = res_q;
  assign bus.Zero       = zero_q;
  assign bus.Overflow   = ovf_q;
  assign bus.valid_out  = valid_q;
  assign bus.ovf_sticky = sticky_q;
endmodule
